// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, cents width, dispenser state encoding.
// Used by the controller, the upstream coin logic and the change dispenser.
package vend_pkg;

  localparam int CENTS_W = 7;

  localparam logic [CENTS_W-1:0] COIN_NICKEL   = 7'd5;
  localparam logic [CENTS_W-1:0] COIN_DIME     = 7'd10;
  localparam logic [CENTS_W-1:0] COIN_QUARTER  = 7'd25;
  localparam logic [CENTS_W-1:0] PRODUCT_PRICE = 7'd65;

  typedef enum logic [1:0] {
    DISP_IDLE   = 2'd0,
    DISP_SELECT = 2'd1,
    DISP_EJECT  = 2'd2,
    DISP_SETTLE = 2'd3
  } disp_state_t;

  function automatic logic [CENTS_W-1:0] cents_sat_add(input logic [CENTS_W-1:0] a,
                                                       input logic [CENTS_W-1:0] b);
    logic [CENTS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CENTS_W] ? {CENTS_W{1'b1}} : s[CENTS_W-1:0];
  endfunction

  // Odd cents below a nickel cannot be paid by any tube and are dropped.
  function automatic logic [CENTS_W-1:0] round_to_nickel(input logic [CENTS_W-1:0] a);
    return (a / COIN_NICKEL) * COIN_NICKEL;
  endfunction

endpackage

// File: rtl/coin_tube_counter.sv
// Saturating up/down inventory counter for one coin tube; 1-cycle update latency.
// Simultaneous inc and dec cancel; dec at zero and inc at full are ignored.
module coin_tube_counter #(
  parameter int W    = 5,
  parameter int INIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= W'(INIT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout over three finite coin tubes, one solenoid pulse per coin, owed balance on shortfall.
// First pulse two cycles after a request; requests arriving while busy accumulate, nothing is dropped.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int NICKEL_INIT  = 8,
  parameter int DIME_INIT    = 8,
  parameter int QUARTER_INIT = 8,
  parameter int CNT_W        = 5,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       change_in,
  input  logic             refill_n,
  input  logic             refill_d,
  input  logic             refill_q,
  input  logic             owed_clr,
  output logic             eject_n,
  output logic             eject_d,
  output logic             eject_q,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [6:0]       owed,
  output logic [CNT_W-1:0] cnt_n,
  output logic [CNT_W-1:0] cnt_d,
  output logic [CNT_W-1:0] cnt_q
);

  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  disp_state_t        state_q, state_d;
  logic [CENTS_W-1:0] remaining_q, remaining_d;
  logic [CENTS_W-1:0] owed_q, owed_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               eject_n_q, eject_n_d;
  logic               eject_d_q, eject_d_d;
  logic               eject_q_q, eject_q_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               short_q, short_d;

  logic               req;
  logic [CENTS_W-1:0] rin;
  logic               pick_n, pick_d, pick_q;
  logic [CENTS_W-1:0] coin_val;
  logic               dec_n, dec_d, dec_q;

  coin_tube_counter #(.W(CNT_W), .INIT(NICKEL_INIT)) u_tube_n (
    .clk(clk), .rst_n(rst_n), .inc(refill_n), .dec(dec_n), .cnt(cnt_n)
  );
  coin_tube_counter #(.W(CNT_W), .INIT(DIME_INIT)) u_tube_d (
    .clk(clk), .rst_n(rst_n), .inc(refill_d), .dec(dec_d), .cnt(cnt_d)
  );
  coin_tube_counter #(.W(CNT_W), .INIT(QUARTER_INIT)) u_tube_q (
    .clk(clk), .rst_n(rst_n), .inc(refill_q), .dec(dec_q), .cnt(cnt_q)
  );

  always_comb begin
    req      = (change_in != '0);
    rin      = round_to_nickel(change_in);
    pick_q   = (remaining_q >= COIN_QUARTER) && (cnt_q != '0);
    pick_d   = !pick_q && (remaining_q >= COIN_DIME) && (cnt_d != '0);
    pick_n   = !pick_q && !pick_d && (remaining_q >= COIN_NICKEL) && (cnt_n != '0);
    coin_val = pick_q ? COIN_QUARTER : (pick_d ? COIN_DIME : COIN_NICKEL);

    state_d     = state_q;
    remaining_d = remaining_q;
    owed_d      = owed_clr ? '0 : owed_q;
    timer_d     = timer_q;
    eject_n_d   = eject_n_q;
    eject_d_d   = eject_d_q;
    eject_q_d   = eject_q_q;
    done_d      = 1'b0;
    short_d     = 1'b0;
    dec_n       = 1'b0;
    dec_d       = 1'b0;
    dec_q       = 1'b0;

    case (state_q)
      DISP_IDLE: begin
        if (req) begin
          remaining_d = rin;
          state_d     = DISP_SELECT;
        end
      end
      DISP_SELECT: begin
        if (pick_q || pick_d || pick_n) begin
          remaining_d = cents_sat_add(remaining_q - coin_val, rin);
          dec_q       = pick_q;
          dec_d       = pick_d;
          dec_n       = pick_n;
          eject_q_d   = pick_q;
          eject_d_d   = pick_d;
          eject_n_d   = pick_n;
          timer_d     = TMR_W'(PULSE_CYCLES - 1);
          state_d     = DISP_EJECT;
        end else begin
          if (remaining_q != '0) begin
            owed_d  = cents_sat_add(owed_d, remaining_q);
            short_d = 1'b1;
          end
          done_d = 1'b1;
          // A request landing on the closing cycle starts a fresh payout right away.
          remaining_d = rin;
          state_d     = req ? DISP_SELECT : DISP_IDLE;
        end
      end
      DISP_EJECT: begin
        remaining_d = cents_sat_add(remaining_q, rin);
        if (timer_q == '0) begin
          eject_n_d = 1'b0;
          eject_d_d = 1'b0;
          eject_q_d = 1'b0;
          timer_d   = TMR_W'(GAP_CYCLES - 1);
          state_d   = DISP_SETTLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DISP_SETTLE: begin
        remaining_d = cents_sat_add(remaining_q, rin);
        if (timer_q == '0) begin
          state_d = DISP_SELECT;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = DISP_IDLE;
    endcase

    busy_d = (state_d != DISP_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DISP_IDLE;
      remaining_q <= '0;
      owed_q      <= '0;
      timer_q     <= '0;
      eject_n_q   <= 1'b0;
      eject_d_q   <= 1'b0;
      eject_q_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      owed_q      <= owed_d;
      timer_q     <= timer_d;
      eject_n_q   <= eject_n_d;
      eject_d_q   <= eject_d_d;
      eject_q_q   <= eject_q_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      short_q     <= short_d;
    end
  end

  assign eject_n = eject_n_q;
  assign eject_d = eject_d_q;
  assign eject_q = eject_q_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign short   = short_q;
  assign owed    = owed_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected coin pulses and done events
// with hand-computed cycles; a negedge monitor pops and compares them as the DUT produces them.
module tb_change_dispenser;

  localparam int PULSE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] change_in = '0;
  logic       refill_n = 1'b0, refill_d = 1'b0, refill_q = 1'b0;
  logic       owed_clr = 1'b0;
  logic       eject_n, eject_d, eject_q;
  logic       busy, done, short;
  logic [6:0] owed;
  logic [4:0] cnt_n, cnt_d, cnt_q;

  change_dispenser #(
    .NICKEL_INIT(8), .DIME_INIT(8), .QUARTER_INIT(8),
    .CNT_W(5), .PULSE_CYCLES(PULSE), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .change_in(change_in),
    .refill_n(refill_n), .refill_d(refill_d), .refill_q(refill_q),
    .owed_clr(owed_clr),
    .eject_n(eject_n), .eject_d(eject_d), .eject_q(eject_q),
    .busy(busy), .done(done), .short(short), .owed(owed),
    .cnt_n(cnt_n), .cnt_d(cnt_d), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 nickel pulse, 1 dime pulse, 2 quarter pulse, 3 done
  typedef struct {
    int kind; int cyc; int shrt; int owed; int cn; int cd; int cq;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_coin(input int kind, input int c);
    exp_t e;
    e = '{kind: kind, cyc: c, shrt: 0, owed: 0, cn: 0, cd: 0, cq: 0};
    sb.push_back(e);
  endtask

  task automatic push_done(input int c, input int s, input int o, input int n, input int d, input int q);
    exp_t e;
    e = '{kind: 3, cyc: c, shrt: s, owed: o, cn: n, cd: d, cq: q};
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int s, input int o, input int n, input int d, input int q);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_unexpected: event kind %0d at cycle %0d with nothing queued", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (e.kind == 3) begin
        chk("done_short", s, e.shrt);
        chk("done_owed", o, e.owed);
        chk("done_cnt_n", n, e.cn);
        chk("done_cnt_d", d, e.cd);
        chk("done_cnt_q", q, e.cq);
      end
    end
  endtask

  // Monitor
  logic [2:0] prev_ej = '0;
  logic [2:0] ej;
  int         wcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ej = '0;
      wcnt    = 0;
    end else begin
      ej = {eject_q, eject_d, eject_n};
      if (ej != '0) wcnt = (prev_ej == '0) ? 1 : wcnt + 1;
      else if (prev_ej != '0) chk("pulse_width", wcnt, PULSE);
      for (int k = 0; k < 3; k++) begin
        if (ej[k] && !prev_ej[k]) begin
          chk("eject_onehot", $countones(ej), 1);
          sb_pop(k, 0, 0, 0, 0, 0);
        end
      end
      if (done) begin
        chk("busy_at_done", int'(busy), 0);
        sb_pop(3, int'(short), int'(owed), int'(cnt_n), int'(cnt_d), int'(cnt_q));
      end
      if (short) chk("short_implies_done", int'(done), 1);
      prev_ej = ej;
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives amt during the next cycle; t receives that cycle index; returns in cycle t+1.
  task automatic issue(input int amt, output int tt);
    tt = cyc + 1;
    wait_to(tt);
    change_in = 7'(amt);
    wait_to(tt + 1);
    change_in = '0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle_timeout: %0d entries still queued, busy %0d", sb.size(), busy);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short), 0);
    chk("rst_eject", int'({eject_q, eject_d, eject_n}), 0);
    chk("rst_owed", int'(owed), 0);
    chk("rst_cnt_n", int'(cnt_n), 8);
    chk("rst_cnt_d", int'(cnt_d), 8);
    chk("rst_cnt_q", int'(cnt_q), 8);
    chk("sb_leftover", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state();
  endtask

  initial begin
    do_reset();

    // 15: dime then nickel
    issue(15, t);
    push_coin(1, t + 2); push_coin(0, t + 9); push_done(t + 16, 0, 0, 7, 7, 8);
    wait_idle();
    do_reset();

    // 40: quarter, dime, nickel
    issue(40, t);
    push_coin(2, t + 2); push_coin(1, t + 9); push_coin(0, t + 16); push_done(t + 23, 0, 0, 7, 7, 7);
    wait_idle();
    do_reset();

    // Drain the quarter tube: 125 then 75
    issue(125, t);
    for (int i = 0; i < 5; i++) push_coin(2, t + 2 + 7 * i);
    push_done(t + 37, 0, 0, 8, 8, 3);
    wait_idle();
    issue(75, t);
    for (int i = 0; i < 3; i++) push_coin(2, t + 2 + 7 * i);
    push_done(t + 23, 0, 0, 8, 8, 0);
    wait_idle();

    // No quarters: 50 as five dimes
    issue(50, t);
    for (int i = 0; i < 5; i++) push_coin(1, t + 2 + 7 * i);
    push_done(t + 37, 0, 0, 8, 3, 0);
    wait_idle();

    // Down to 1 nickel, no dimes: 30 then 35
    issue(30, t);
    for (int i = 0; i < 3; i++) push_coin(1, t + 2 + 7 * i);
    push_done(t + 23, 0, 0, 8, 0, 0);
    wait_idle();
    issue(35, t);
    for (int i = 0; i < 7; i++) push_coin(0, t + 2 + 7 * i);
    push_done(t + 51, 0, 0, 1, 0, 0);
    wait_idle();

    // 15 with one nickel: short 10
    issue(15, t);
    push_coin(0, t + 2); push_done(t + 9, 1, 10, 0, 0, 0);
    wait_idle();
    owed_clr = 1'b1;
    wait_to(cyc + 1);
    owed_clr = 1'b0;
    wait_to(cyc + 1);
    chk("owed_after_clr", int'(owed), 0);

    // Empty tubes: immediate short, then short of 23 (rounded to 20) with clear in the same cycle
    issue(10, t);
    push_done(t + 2, 1, 10, 0, 0, 0);
    wait_idle();
    issue(23, t);
    owed_clr = 1'b1;
    push_done(t + 2, 1, 20, 0, 0, 0);
    wait_to(t + 2);
    owed_clr = 1'b0;
    wait_idle();

    // Two nickel refills then 10: two nickels, owed untouched
    refill_n = 1'b1; wait_to(cyc + 1);
    refill_n = 1'b0; wait_to(cyc + 1);
    refill_n = 1'b1; wait_to(cyc + 1);
    refill_n = 1'b0;
    issue(10, t);
    push_coin(0, t + 2); push_coin(0, t + 9); push_done(t + 16, 0, 20, 0, 0, 0);
    wait_idle();
    do_reset();

    // 15, then 25 mid-EJECT, refill_q on the quarter decrement cycle
    issue(15, t);
    push_coin(1, t + 2); push_coin(2, t + 9); push_coin(0, t + 16); push_done(t + 23, 0, 0, 7, 7, 8);
    wait_to(t + 3);
    change_in = 7'd25;
    wait_to(t + 4);
    change_in = '0;
    wait_to(t + 8);
    refill_q = 1'b1;
    wait_to(t + 9);
    refill_q = 1'b0;
    wait_idle();

    // Reset during EJECT: solenoid must drop without a clock edge
    issue(15, t);
    push_coin(1, t + 2);
    wait_to(t + 3);
    chk("eject_d_before_rst", int'(eject_d), 1);
    rst_n = 1'b0;
    #1;
    chk("eject_d_async_drop", int'(eject_d), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state();

    // Still functional afterwards
    issue(5, t);
    push_coin(0, t + 2); push_done(t + 9, 0, 0, 7, 8, 8);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
